// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and default sizes for the Gray stream monitor
package gray_pkg;

    // Default word width of the Gray / binary path.
    localparam int GRAY_WIDTH = 4;
    // Default width of the saturating illegal-step counter.
    localparam int GRAY_ERR_W = 8;

    // Monitor state:
    //   IDLE     - no reference sample held
    //   ACQUIRE  - one reference held, direction not yet established
    //   LOCKED   - direction established, steps are being policed
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Classification of the modular binary delta between two samples.
    typedef enum logic [1:0] {
        ZERO    = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2,
        ILLEGAL = 2'd3
    } delta_class_t;

endpackage

// File: rtl/gray_to_binary.sv
// rtl/gray_to_binary.sv - combinational Gray-to-binary decoder
//
// Ports:
//   g  in  [WIDTH-1:0]  Gray-coded word
//   b  out [WIDTH-1:0]  binary value; b[i] is the XOR of g[WIDTH-1:i]
module gray_to_binary #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    // Each bit is a reduction XOR of the Gray bits at or above it, which
    // avoids a ripple chain through b itself.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign b[i] = ^g[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_stream_monitor.sv
// rtl/gray_stream_monitor.sv - run-time checker for a Gray-coded counter stream
//
// Ports:
//   clk        in                rising-edge clock
//   rst_n      in                asynchronous active-low reset
//   clear      in                synchronous clear: FSM to IDLE, err_count to 0
//   valid      in                g carries a new sample this cycle
//   g          in  [WIDTH-1:0]   Gray-coded input word
//   b          out [WIDTH-1:0]   binary decode of the last accepted sample
//   b_valid    out               one-cycle pulse: b updated
//   dir        out               current direction, 1 = up, 0 = down
//   locked     out               high while the FSM is in LOCKED
//   step_err   out               one-cycle pulse: illegal step detected
//   err_count  out [ERR_W-1:0]   saturating count of illegal steps
module gray_stream_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH,
    parameter int ERR_W = GRAY_ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b,
    output logic             b_valid,
    output logic             dir,
    output logic             locked,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [WIDTH-1:0] DELTA_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] DELTA_ONES = {WIDTH{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

    state_t           state;
    state_t           state_next;
    delta_class_t     delta_class;
    logic [WIDTH-1:0] bin_new;
    logic [WIDTH-1:0] delta;
    logic             dir_next;
    logic             load;
    logic             err_hit;

    gray_to_binary #(
        .WIDTH (WIDTH)
    ) u_gray_to_binary (
        .g (g),
        .b (bin_new)
    );

    // Modular difference against the held reference; wrap-around falls out
    // of the WIDTH-bit subtraction (max->0 gives 1, 0->max gives all ones).
    assign delta = bin_new - b;

    always_comb begin
        delta_class = ILLEGAL;
        if (delta == '0) begin
            delta_class = ZERO;
        end else if (delta == DELTA_ONE) begin
            delta_class = UP;
        end else if (delta == DELTA_ONES) begin
            delta_class = DOWN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the per-sample decisions. clear wins over valid: the
    // sample is dropped and no pulses are produced.
    always_comb begin
        state_next = state;
        dir_next   = dir;
        load       = 1'b0;
        err_hit    = 1'b0;
        if (clear) begin
            state_next = IDLE;
        end else if (valid) begin
            load = 1'b1;
            unique case (state)
                IDLE: begin
                    state_next = ACQUIRE;
                end
                ACQUIRE: begin
                    // Illegal deltas here are not errors: with no direction
                    // established the new sample simply becomes the reference.
                    if (delta_class == UP) begin
                        dir_next   = 1'b1;
                        state_next = LOCKED;
                    end else if (delta_class == DOWN) begin
                        dir_next   = 1'b0;
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (delta_class == UP) begin
                        dir_next = 1'b1;
                    end else if (delta_class == DOWN) begin
                        dir_next = 1'b0;
                    end else if (delta_class == ILLEGAL) begin
                        // Direction is kept so a relock can be compared
                        // against the pre-error trend by downstream logic.
                        err_hit    = 1'b1;
                        state_next = ACQUIRE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b         <= '0;
            b_valid   <= 1'b0;
            dir       <= 1'b1;
            locked    <= 1'b0;
            step_err  <= 1'b0;
            err_count <= '0;
        end else begin
            b_valid  <= load;
            step_err <= err_hit;
            dir      <= dir_next;
            // Registered decode of the upcoming state so locked lines up
            // with the sample that caused the transition.
            locked   <= (state_next == LOCKED);
            if (load) begin
                b <= bin_new;
            end
            if (clear) begin
                err_count <= '0;
            end else if (err_hit && (err_count != ERR_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_stream_monitor.sv
// tb/tb_gray_stream_monitor.sv - directed self-checking bench for gray_stream_monitor
module tb_gray_stream_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       valid;
    logic [3:0] g;

    logic [3:0] b_a;
    logic       b_valid_a;
    logic       dir_a;
    logic       locked_a;
    logic       step_err_a;
    logic [7:0] err_count_a;

    logic [3:0] b_s;
    logic       b_valid_s;
    logic       dir_s;
    logic       locked_s;
    logic       step_err_s;
    logic [1:0] err_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_stream_monitor #(
        .WIDTH (4),
        .ERR_W (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .valid     (valid),
        .g         (g),
        .b         (b_a),
        .b_valid   (b_valid_a),
        .dir       (dir_a),
        .locked    (locked_a),
        .step_err  (step_err_a),
        .err_count (err_count_a)
    );

    gray_stream_monitor #(
        .WIDTH (4),
        .ERR_W (2)
    ) u_dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .valid     (valid),
        .g         (g),
        .b         (b_s),
        .b_valid   (b_valid_s),
        .dir       (dir_s),
        .locked    (locked_s),
        .step_err  (step_err_s),
        .err_count (err_count_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle; the sample is given as a binary value and Gray-encoded here.
    task automatic cycle(input logic v, input logic [3:0] bin, input logic clr);
        valid = v;
        clear = clr;
        g     = bin ^ (bin >> 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [3:0] eb, input logic ebv,
                              input logic elk, input logic edr, input logic ese,
                              input logic [7:0] eca, input logic [1:0] ecs);
        check({tag, ".b"},         32'(b_a),         32'(eb));
        check({tag, ".b_valid"},   32'(b_valid_a),   32'(ebv));
        check({tag, ".locked"},    32'(locked_a),    32'(elk));
        check({tag, ".dir"},       32'(dir_a),       32'(edr));
        check({tag, ".step_err"},  32'(step_err_a),  32'(ese));
        check({tag, ".err_count"}, 32'(err_count_a), 32'(eca));
        check({tag, ".sat_b"},     32'(b_s),         32'(eb));
        check({tag, ".sat_err"},   32'(step_err_s),  32'(ese));
        check({tag, ".sat_count"}, 32'(err_count_s), 32'(ecs));
    endtask

    initial begin
        logic [3:0] ill_tab [4];
        logic [3:0] rel_tab [4];
        ill_tab = '{4'd10, 4'd14, 4'd2, 4'd6};
        rel_tab = '{4'd11, 4'd15, 4'd3, 4'd7};

        rst_n = 1'b0;
        clear = 1'b0;
        valid = 1'b0;
        g     = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        expect_all("reset", 4'd0, 0, 0, 1, 0, 8'd0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Count up from zero, back-to-back.
        cycle(1, 4'd0, 0);  expect_all("up0", 4'd0, 1, 0, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd1, 0);  expect_all("up1", 4'd1, 1, 1, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd2, 0);  expect_all("up2", 4'd2, 1, 1, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd3, 0);  expect_all("up3", 4'd3, 1, 1, 1, 0, 8'd0, 2'd0);
        cycle(0, 4'd3, 0);  expect_all("hold", 4'd3, 0, 1, 1, 0, 8'd0, 2'd0);
        cycle(0, 4'd0, 1);  expect_all("clr", 4'd3, 0, 0, 1, 0, 8'd0, 2'd0);

        // Wrap-around both ways.
        cycle(1, 4'd14, 0); expect_all("wr14", 4'd14, 1, 0, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd15, 0); expect_all("wr15", 4'd15, 1, 1, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd0, 0);  expect_all("wr0", 4'd0, 1, 1, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd15, 0); expect_all("wrdn", 4'd15, 1, 1, 0, 0, 8'd0, 2'd0);

        // Illegal step while locked, then relock.
        cycle(1, 4'd0, 0);  expect_all("rv0", 4'd0, 1, 1, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd1, 0);  expect_all("rv1", 4'd1, 1, 1, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd2, 0);  expect_all("rv2", 4'd2, 1, 1, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd5, 0);  expect_all("ill5", 4'd5, 1, 0, 1, 1, 8'd1, 2'd1);
        cycle(0, 4'd5, 0);  expect_all("ill_end", 4'd5, 0, 0, 1, 0, 8'd1, 2'd1);
        cycle(1, 4'd7, 0);  expect_all("acq_ill", 4'd7, 1, 0, 1, 0, 8'd1, 2'd1);
        cycle(1, 4'd6, 0);  expect_all("relock", 4'd6, 1, 1, 0, 0, 8'd1, 2'd1);
        cycle(1, 4'd7, 0);  expect_all("reverse", 4'd7, 1, 1, 1, 0, 8'd1, 2'd1);

        // Four more illegal steps, relocking between them.
        for (int k = 0; k < 4; k++) begin
            cycle(1, ill_tab[k], 0);
            expect_all($sformatf("sat_ill%0d", k), ill_tab[k], 1, 0, 1, 1,
                       8'(2 + k), (k >= 1) ? 2'd3 : 2'(2 + k));
            cycle(1, rel_tab[k], 0);
            expect_all($sformatf("sat_rel%0d", k), rel_tab[k], 1, 1, 1, 0,
                       8'(2 + k), (k >= 1) ? 2'd3 : 2'(2 + k));
        end

        // clear beats valid.
        cycle(1, 4'd8, 1);  expect_all("clr_vld", 4'd7, 0, 0, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd8, 0);  expect_all("after_clr", 4'd8, 1, 0, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd9, 0);  expect_all("lk9", 4'd9, 1, 1, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd8, 0);  expect_all("lk8", 4'd8, 1, 1, 0, 0, 8'd0, 2'd0);

        // Asynchronous reset between samples.
        valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        expect_all("arst", 4'd0, 0, 0, 1, 0, 8'd0, 2'd0);
        #2;
        rst_n = 1'b1;
        cycle(1, 4'd5, 0);  expect_all("post5", 4'd5, 1, 0, 1, 0, 8'd0, 2'd0);
        cycle(1, 4'd6, 0);  expect_all("post6", 4'd6, 1, 1, 1, 0, 8'd0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
